hc595_chain_driver: RTL

//   Parametrised serial driver for a daisy chain of N_CHIPS 74HC595 shift registers.

---
 rtl/hc595_pkg.sv | 26 ++
 rtl/hc595_tick_gen.sv | 38 +++
 rtl/hc595_chain_driver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/hc595_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_pkg
//  Description : Shared types for the 74HC595 chain driver. Holds the
//                transfer FSM state encoding and the chain-width helper.
//  Config      : none (HC595_OE_PWM_EN is consumed by hc595_chain_driver)
//  Revision    : 1.0  initial release
// ============================================================================
package hc595_pkg;

  // Transfer FSM states, 3-bit explicit encoding
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    GAP      = 3'd4
  } state_t;

  // Serial word width for a chain of n_chips 595s
  function automatic int chain_width(input int n_chips);
    return 8 * n_chips;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hc595_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_tick_gen
//  Description : Divide-by-DIV tick generator. o_tick is high for one clk
//                cycle every DIV cycles. i_restart forces the counter back
//                to 0 so the next tick lands exactly DIV cycles later.
//  Ports       : clk, rst (async, active-high), i_restart, o_tick
//  Revision    : 1.0  initial release
// ============================================================================
module hc595_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int c_CNT_W = $clog2(DIV + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_tick;

  assign w_tick = (r_cnt == c_CNT_W'(DIV - 1));
  assign o_tick = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hc595_chain_driver.sv
`default_nettype none
// ============================================================================
//  Module      : hc595_chain_driver
//  Description : Serial driver for a daisy chain of N_CHIPS 74HC595s.
//                Captures an 8*N_CHIPS bit word on start, shifts it out
//                MSB-first on DS/SHCP, pulses STCP to latch it, then pulses
//                done. Each serial phase lasts DIV clk cycles.
//  Ports       : clk, rst (async, active-high)
//                start, dat[W-1:0]         - request / word in
//                busy, done                - handshake status
//                DS, SHCP, STCP, oe_n      - 595 chain pins
//                bright[7:0]               - PWM duty (HC595_OE_PWM_EN only)
//  Config      : `define HC595_OE_PWM_EN adds the bright port and drives
//                oe_n from a free-running 8-bit PWM; otherwise oe_n = 0.
//  Revision    : 1.0  initial release
// ============================================================================
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int N_CHIPS = 1,
  parameter int DIV     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [chain_width(N_CHIPS)-1:0] dat,
  output logic                           busy,
  output logic                           done,
  output logic                           DS,
  output logic                           SHCP,
  output logic                           STCP,
  output logic                           oe_n
`ifdef HC595_OE_PWM_EN
  ,
  input  logic [7:0]                     bright
`endif
);

  localparam int c_W     = chain_width(N_CHIPS);
  localparam int c_IDX_W = $clog2(c_W);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_W-1:0]     r_shadow;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_busy;
  logic               r_done;
  logic               w_tick;
  logic               w_accept;
  logic               w_ds;
  logic               w_shcp;
  logic               w_stcp;

  // A start in the done cycle is not taken; it must still be high one
  // cycle later, leaving exactly one IDLE cycle between transfers.
  assign w_accept = (r_state == IDLE) && start && !r_done;

  hc595_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_accept),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ds        = 1'b0;
    w_shcp      = 1'b0;
    w_stcp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = SHIFT_LO;
      end
      SHIFT_LO: begin
        w_ds = r_shadow[r_idx];
        if (w_tick) w_state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        // DS keeps the same bit through the high phase for hold time
        w_ds   = r_shadow[r_idx];
        w_shcp = 1'b1;
        if (w_tick) w_state_nxt = (r_idx == '0) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        w_stcp = 1'b1;
        if (w_tick) w_state_nxt = GAP;
      end
      GAP: begin
        if (w_tick) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shadow <= dat;
        r_idx    <= c_IDX_W'(c_W - 1);
        r_busy   <= 1'b1;
      end else if ((r_state == SHIFT_HI) && w_tick && (r_idx != '0)) begin
        r_idx <= r_idx - c_IDX_W'(1);
      end else if ((r_state == GAP) && w_tick) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign DS   = w_ds;
  assign SHCP = w_shcp;
  assign STCP = w_stcp;

`ifdef HC595_OE_PWM_EN
  logic [7:0] r_pwm_cnt;
  logic       r_oe_n;

  // Free-running dimmer, independent of the transfer FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= 8'd0;
      r_oe_n    <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_oe_n    <= (r_pwm_cnt >= bright);
    end
  end

  assign oe_n = r_oe_n;
`else
  assign oe_n = 1'b0;
`endif

endmodule
`default_nettype wire
